// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer: same-cycle fetch lookup, EX update on the clock edge.
// Optional statistics ports/counters are built when BTB_PERF_CNT_EN is defined.
module btb_set_assoc #(
   parameter int BTB_ENTRIES = 64,
   parameter int WAYS        = 2,
   parameter int CNT_WIDTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetchPc,
   output logic        fetchHit,
   output logic [31:0] fetchTarget,
   input  logic        exBranch,
   input  logic        exTaken,
   input  logic [31:0] exPc,
   input  logic [31:0] exTarget
`ifdef BTB_PERF_CNT_EN
   ,
   output logic [31:0] lookupCnt,
   output logic [31:0] hitCnt,
   output logic [31:0] allocCnt
`endif
);

   localparam int SETS        = BTB_ENTRIES / WAYS;
   localparam int INDEX_WIDTH = $clog2(SETS);
   localparam int TAG_WIDTH   = 30 - INDEX_WIDTH;
   localparam int IW          = (INDEX_WIDTH > 0) ? INDEX_WIDTH : 1;
   localparam int PW          = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WT          = 1 << (CNT_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [IW-1:0] idx_of(input logic [31:0] pc);
      if (INDEX_WIDTH == 0) return '0;
      else                  return pc[IW+1:2];
   endfunction

   logic [WAYS-1:0]      valid  [SETS];
   logic [TAG_WIDTH-1:0] tagMem [SETS][WAYS];
   logic [31:0]          tgtMem [SETS][WAYS];
   logic [CNT_WIDTH-1:0] cntMem [SETS][WAYS];

   logic [IW-1:0]        fIdx, eIdx;
   logic [TAG_WIDTH-1:0] fTag, eTag;
   logic                 unused_pc_lsbs;

   assign fIdx = idx_of(fetchPc);
   assign eIdx = idx_of(exPc);
   assign fTag = fetchPc[31:INDEX_WIDTH+2];
   assign eTag = exPc[31:INDEX_WIDTH+2];
   assign unused_pc_lsbs = ^{fetchPc[1:0], exPc[1:0]};

   // Loops run downward so the lowest matching / invalid way is the one kept.
   logic          fMatch, eMatch, eHasInv;
   logic [PW-1:0] fWay, eWay, eInv, victim, curPtr;

   always_comb begin
      fMatch = 1'b0;
      fWay   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[fIdx][w] && tagMem[fIdx][w] == fTag) begin
            fMatch = 1'b1;
            fWay   = PW'(w);
         end
      end
   end

   always_comb begin
      eMatch  = 1'b0;
      eWay    = '0;
      eHasInv = 1'b0;
      eInv    = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[eIdx][w] && tagMem[eIdx][w] == eTag) begin
            eMatch = 1'b1;
            eWay   = PW'(w);
         end
         if (!valid[eIdx][w]) begin
            eHasInv = 1'b1;
            eInv    = PW'(w);
         end
      end
   end

   assign victim      = eHasInv ? eInv : curPtr;
   assign fetchHit    = fMatch && cntMem[fIdx][fWay][CNT_WIDTH-1];
   assign fetchTarget = fMatch ? tgtMem[fIdx][fWay] : 32'h0;

   logic [CNT_WIDTH-1:0] eCnt, eCntNext;
   assign eCnt     = cntMem[eIdx][eWay];
   assign eCntNext = exTaken ? ((eCnt == CNT_MAX) ? eCnt : eCnt + 1'b1)
                             : ((eCnt == '0)      ? eCnt : eCnt - 1'b1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end else if (exBranch && !eMatch) begin
         valid[eIdx][victim] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (rst && exBranch) begin
         if (eMatch) begin
            cntMem[eIdx][eWay] <= eCntNext;
            if (exTaken) tgtMem[eIdx][eWay] <= exTarget;
         end else begin
            tagMem[eIdx][victim] <= eTag;
            tgtMem[eIdx][victim] <= exTarget;
            cntMem[eIdx][victim] <= exTaken ? CNT_WIDTH'(WT) : CNT_WIDTH'(WT - 1);
         end
      end
   end

   generate
      if (WAYS > 1) begin : g_ptr
         logic [PW-1:0] ptr [SETS];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int s = 0; s < SETS; s++) ptr[s] <= '0;
            end else if (exBranch && !eMatch && !eHasInv) begin
               ptr[eIdx] <= ptr[eIdx] + 1'b1;
            end
         end
         assign curPtr = ptr[eIdx];
      end else begin : g_noptr
         assign curPtr = '0;
      end
   endgenerate

`ifdef BTB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         lookupCnt <= '0;
         hitCnt    <= '0;
         allocCnt  <= '0;
      end else begin
         lookupCnt <= lookupCnt + 32'd1;
         if (fetchHit)              hitCnt   <= hitCnt + 32'd1;
         if (exBranch && !eMatch)   allocCnt <= allocCnt + 32'd1;
      end
   end
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc (64 entries, 2 ways, 2-bit counters): vector table plus reset/replacement sequences.
module tb_btb_set_assoc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fetchPc = '0;
   logic        fetchHit;
   logic [31:0] fetchTarget;
   logic        exBranch = 1'b0;
   logic        exTaken  = 1'b0;
   logic [31:0] exPc     = '0;
   logic [31:0] exTarget = '0;
`ifdef BTB_PERF_CNT_EN
   logic [31:0] lookupCnt, hitCnt, allocCnt;
`endif

   always #5 clk = ~clk;

   btb_set_assoc dut (
      .clk(clk), .rst(rst),
      .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
      .exBranch(exBranch), .exTaken(exTaken), .exPc(exPc), .exTarget(exTarget)
`ifdef BTB_PERF_CNT_EN
      , .lookupCnt(lookupCnt), .hitCnt(hitCnt), .allocCnt(allocCnt)
`endif
   );

   typedef struct {
      logic        b, t;
      logic [31:0] ep, et, fp;
      logic        eh;
      logic [31:0] etg;
   } vec_t;

   typedef struct {
      logic        hit;
      logic [31:0] tgt;
      string       name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   nChk = 0;
   int   nFail = 0;

   function automatic void v(input logic b, input logic t, input logic [31:0] ep,
                             input logic [31:0] et, input logic [31:0] fp,
                             input logic eh, input logic [31:0] etg);
      vec_t x;
      x.b = b; x.t = t; x.ep = ep; x.et = et; x.fp = fp; x.eh = eh; x.etg = etg;
      tbl.push_back(x);
   endfunction

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      nChk++;
      if (fetchHit !== e.hit || fetchTarget !== e.tgt) begin
         nFail++;
         $display("FAIL %s: got hit=%0b target=%h, want hit=%0b target=%h",
                  e.name, fetchHit, fetchTarget, e.hit, e.tgt);
      end
   endtask

   // One cycle: drive fetch + EX inputs, check fetch outputs before the update edge.
   task automatic cyc(input logic b, input logic t, input logic [31:0] ep, input logic [31:0] et,
                      input logic [31:0] fp, input logic eh, input logic [31:0] etg, input string nm);
      exp_t e;
      @(negedge clk);
      rst = 1'b1;
      exBranch = b; exTaken = t; exPc = ep; exTarget = et; fetchPc = fp;
      e.hit = eh; e.tgt = etg; e.name = nm;
      sb.push_back(e);
      #2 check_out();
   endtask

   task automatic fetch(input logic [31:0] fp, input logic eh, input logic [31:0] etg, input string nm);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, fp, eh, etg, nm);
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
      nChk++;
      if (got !== want) begin
         nFail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   initial begin
      // reset / first allocation / same-cycle collision
      v(0,0,0,0,           'h100, 0, 'h0);
      v(1,1,'h100,'h200,   'h100, 0, 'h0);
      v(0,0,0,0,           'h100, 1, 'h200);
      v(1,0,'h100,'h999,   'h100, 1, 'h200);
      v(0,0,0,0,           'h100, 0, 'h200);
      // saturate up: counts 1,2,3,3,3
      v(1,1,'h100,'h200,   'h100, 0, 'h200);
      for (int i = 0; i < 4; i++) v(1,1,'h100,'h200, 'h100, 1, 'h200);
      v(1,0,'h100,'h800,   'h100, 1, 'h200);
      v(0,0,0,0,           'h100, 1, 'h200);
      v(1,0,'h100,'h800,   'h100, 1, 'h200);
      v(0,0,0,0,           'h100, 0, 'h200);
      // saturate down to 0, then one taken -> 1
      for (int i = 0; i < 5; i++) v(1,0,'h100,'h800, 'h100, 0, 'h200);
      v(1,1,'h100,'h200,   'h100, 0, 'h200);
      v(0,0,0,0,           'h100, 0, 'h200);
      // target refresh on taken hit only
      v(1,1,'h100,'h400,   'h100, 0, 'h200);
      v(0,0,0,0,           'h100, 1, 'h400);
      v(1,0,'h100,'h800,   'h100, 1, 'h400);
      v(1,1,'h100,'h400,   'h100, 0, 'h400);
      v(0,0,0,0,           'h100, 1, 'h400);
      // associativity in set 0
      v(1,1,'h300,'h3000,  'h300, 0, 'h0);
      v(0,0,0,0,           'h100, 1, 'h400);
      v(0,0,0,0,           'h300, 1, 'h3000);
      v(1,1,'h500,'h5000,  'h500, 0, 'h0);
      v(0,0,0,0,           'h100, 0, 'h0);
      v(0,0,0,0,           'h500, 1, 'h5000);
      v(0,0,0,0,           'h300, 1, 'h3000);
      v(1,1,'h700,'h7000,  'h700, 0, 'h0);
      v(0,0,0,0,           'h300, 0, 'h0);
      v(0,0,0,0,           'h700, 1, 'h7000);
      v(0,0,0,0,           'h500, 1, 'h5000);
      // not-taken allocation in set 1, low PC bits ignored, idle EX
      v(1,0,'h104,'h1040,  'h104, 0, 'h0);
      v(0,0,0,0,           'h104, 0, 'h1040);
      v(0,0,0,0,           'h107, 0, 'h1040);
      v(0,1,'h104,'hdead,  'h104, 0, 'h1040);
      v(0,0,0,0,           'h104, 0, 'h1040);

      rst = 1'b0;
      @(negedge clk);
      foreach (tbl[i])
         cyc(tbl[i].b, tbl[i].t, tbl[i].ep, tbl[i].et, tbl[i].fp, tbl[i].eh, tbl[i].etg,
             $sformatf("vec%0d", i));

      // pointer is 0 here; this eviction moves it to 1 before reset
      cyc(1,1,'h900,'h9000, 'h900, 0, 'h0, "alloc_900");
      fetch('h500, 0, 'h0,    "evicted_500");
      fetch('h900, 1, 'h9000, "hit_900");

      // reset with a simultaneous EX allocation: nothing survives, nothing is written
      @(negedge clk);
      rst = 1'b0; exBranch = 1'b1; exTaken = 1'b1; exPc = 'hB00; exTarget = 'hB000;
      fetch('h900, 0, 'h0, "rst_900");
      fetch('h700, 0, 'h0, "rst_700");
      fetch('h104, 0, 'h0, "rst_104");
      fetch('hB00, 0, 'h0, "rst_B00");

      // pointer must have returned to 0: third allocation evicts way 0
      cyc(1,1,'h100,'h1000, 'h100, 0, 'h0, "realloc_100");
      cyc(1,1,'h300,'h3000, 'h300, 0, 'h0, "realloc_300");
      cyc(1,1,'h500,'h5000, 'h500, 0, 'h0, "realloc_500");
      fetch('h100, 0, 'h0,    "ptr_evict_100");
      fetch('h300, 1, 'h3000, "ptr_keep_300");
      fetch('h500, 1, 'h5000, "ptr_new_500");

`ifdef BTB_PERF_CNT_EN
      @(negedge clk);
      rst = 1'b0; exBranch = 1'b0;
      cyc(1,1,'h100,'h1000, 'h000, 0, 'h0, "perf_alloc0");
      cyc(1,1,'h104,'h1040, 'h000, 0, 'h0, "perf_alloc1");
      for (int i = 0; i < 3; i++) fetch('h100, 1, 'h1000, "perf_hit");
      for (int i = 0; i < 5; i++) fetch('h000, 0, 'h0, "perf_miss");
      @(negedge clk);
      exBranch = 1'b0;
      chk32("lookupCnt", lookupCnt, 32'd10);
      chk32("hitCnt",    hitCnt,    32'd3);
      chk32("allocCnt",  allocCnt,  32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
